// File: rtl/serializer_pkg.sv
// rtl/serializer_pkg.sv - shared defaults, state encodings and length limits for the serializer
//
// Optional build macro used by the serializer: SERIALIZER_LSB_FIRST_EN.

package serializer_pkg;

  // Default word width and the matching width of the bit-count field.
  localparam int unsigned SER_DATA_W_DEF = 16;
  localparam int unsigned SER_MOD_W_DEF  = $clog2(SER_DATA_W_DEF) + 1;

  // Smallest bit count accepted; counts of 1 or 2 are dropped.
  localparam int unsigned SER_MIN_MOD = 3;

  // FSM state encodings.
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

endpackage

// File: rtl/serializer.sv
// rtl/serializer.sv - parallel-to-serial converter sending the top N bits of a word, one per clock
//
// Ports:
//   clk_i           clock, all logic on the rising edge
//   srst_i          synchronous reset, active-high
//   data_i          parallel word (DATA_W bits)
//   data_mod_i      bit count from data_i[DATA_W-1] downward; 0 or >DATA_W means DATA_W, 1..2 dropped
//   data_val_i      data_i/data_mod_i valid (ignored while busy_o is high)
//   ser_data_o      serial bit, 0 whenever ser_data_val_o is low
//   ser_data_val_o  serial bit valid
//   busy_o          transfer in progress
//
// Build macro SERIALIZER_LSB_FIRST_EN: when defined the same N bits are sent
// in reverse order (data_i[DATA_W-N] first); default is MSB first.

module serializer
  import serializer_pkg::*;
#(
  parameter int unsigned DATA_W = SER_DATA_W_DEF,
  parameter int unsigned MOD_W  = $clog2(DATA_W) + 1
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [MOD_W-1:0]  data_mod_i,
  input  logic              data_val_i,
  output logic              ser_data_o,
  output logic              ser_data_val_o,
  output logic              busy_o
);

  logic [0:0]        state_q;
  logic [DATA_W-1:0] shift_q;
  logic [MOD_W-1:0]  cnt_q;

  logic [MOD_W-1:0]  n_len;
  logic              len_ok;
  logic              first_bit;
  logic [DATA_W-1:0] load_next;
  logic              next_bit;
  logic [DATA_W-1:0] shift_next;

  always_comb begin
    n_len = data_mod_i;
    if (data_mod_i == '0 || data_mod_i > MOD_W'(DATA_W)) begin
      n_len = MOD_W'(DATA_W);
    end
    len_ok = (n_len >= MOD_W'(SER_MIN_MOD));

`ifdef SERIALIZER_LSB_FIRST_EN
    // Right-align the selected N bits so the lowest of them leaves first.
    first_bit  = data_i[DATA_W - 32'(n_len)];
    load_next  = (data_i >> (MOD_W'(DATA_W) - n_len)) >> 1;
    next_bit   = shift_q[0];
    shift_next = shift_q >> 1;
`else
    first_bit  = data_i[DATA_W-1];
    load_next  = data_i << 1;
    next_bit   = shift_q[DATA_W-1];
    shift_next = shift_q << 1;
`endif
  end

  // The first bit is registered at the accepting edge itself, so the shift
  // register holds the remaining bits and cnt_q counts those still to go.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q        <= ST_IDLE;
      shift_q        <= '0;
      cnt_q          <= '0;
      ser_data_o     <= 1'b0;
      ser_data_val_o <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ser_data_o     <= 1'b0;
          ser_data_val_o <= 1'b0;
          busy_o         <= 1'b0;
          if (data_val_i && len_ok) begin
            state_q        <= ST_SHIFT;
            shift_q        <= load_next;
            cnt_q          <= n_len - MOD_W'(1);
            ser_data_o     <= first_bit;
            ser_data_val_o <= 1'b1;
            busy_o         <= 1'b1;
          end
        end
        default: begin
          if (cnt_q == '0) begin
            state_q        <= ST_IDLE;
            ser_data_o     <= 1'b0;
            ser_data_val_o <= 1'b0;
            busy_o         <= 1'b0;
          end else begin
            shift_q        <= shift_next;
            cnt_q          <= cnt_q - MOD_W'(1);
            ser_data_o     <= next_bit;
            ser_data_val_o <= 1'b1;
            busy_o         <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serializer.sv
// tb/tb_serializer.sv - directed self-checking bench for the serializer

module tb_serializer;

  logic        clk_i = 1'b0;
  logic        srst_i = 1'b1;
  logic [15:0] data_i = '0;
  logic [4:0]  data_mod_i = '0;
  logic        data_val_i = 1'b0;
  logic        ser_data_o;
  logic        ser_data_val_o;
  logic        busy_o;

  int tests_run = 0;
  int tests_failed = 0;

  serializer dut (
    .clk_i          (clk_i),
    .srst_i         (srst_i),
    .data_i         (data_i),
    .data_mod_i     (data_mod_i),
    .data_val_i     (data_val_i),
    .ser_data_o     (ser_data_o),
    .ser_data_val_o (ser_data_val_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Expected k-th transmitted bit of word w sent with length n.
  function automatic logic exp_bit(input logic [15:0] w, input int n, input int k);
`ifdef SERIALIZER_LSB_FIRST_EN
    return w[16 - n + k];
`else
    return w[15 - k];
`endif
  endfunction

  // Present one word for a single cycle; returns at the negedge after the
  // accepting edge, where bit 0 should be visible.
  task automatic present(input logic [15:0] w, input logic [4:0] m);
    @(negedge clk_i);
    data_i     = w;
    data_mod_i = m;
    data_val_i = 1'b1;
    @(negedge clk_i);
    data_val_i = 1'b0;
  endtask

  task automatic test_reset;
    srst_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      if (c == 2) srst_i = 1'b0;
      tests_run++;
      if (ser_data_o !== 1'b0 || ser_data_val_o !== 1'b0 || busy_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset c%0d: data=%b val=%b busy=%b expected 0 0 0", c, ser_data_o, ser_data_val_o, busy_o);
      end
    end
    @(negedge clk_i);
    tests_run++;
    if (ser_data_o !== 1'b0 || ser_data_val_o !== 1'b0 || busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_after: data=%b val=%b busy=%b expected 0 0 0", ser_data_o, ser_data_val_o, busy_o);
    end
  endtask

  task automatic test_full_word;
    logic [15:0] seq;
    seq = 16'b1010_0101_1100_0011;
    present(16'hA5C3, 5'd0);
    for (int k = 0; k < 16; k++) begin
      tests_run++;
      if (ser_data_val_o !== 1'b1 || busy_o !== 1'b1 || ser_data_o !== exp_bit(seq, 16, k)) begin
        tests_failed++;
        $display("FAIL full bit%0d: data=%b val=%b busy=%b expected data=%b val=1 busy=1",
                 k, ser_data_o, ser_data_val_o, busy_o, exp_bit(seq, 16, k));
      end
      @(negedge clk_i);
    end
    tests_run++;
    if (ser_data_o !== 1'b0 || ser_data_val_o !== 1'b0 || busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_end: data=%b val=%b busy=%b expected 0 0 0", ser_data_o, ser_data_val_o, busy_o);
    end
  endtask

  task automatic test_partial_word;
    present(16'hF000, 5'd5);
    for (int k = 0; k < 5; k++) begin
      tests_run++;
      if (ser_data_val_o !== 1'b1 || busy_o !== 1'b1 || ser_data_o !== exp_bit(16'hF000, 5, k)) begin
        tests_failed++;
        $display("FAIL partial bit%0d: data=%b val=%b busy=%b expected data=%b val=1 busy=1",
                 k, ser_data_o, ser_data_val_o, busy_o, exp_bit(16'hF000, 5, k));
      end
      @(negedge clk_i);
    end
    for (int c = 0; c < 3; c++) begin
      tests_run++;
      if (ser_data_o !== 1'b0 || ser_data_val_o !== 1'b0 || busy_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL partial_end c%0d: data=%b val=%b busy=%b expected 0 0 0", c, ser_data_o, ser_data_val_o, busy_o);
      end
      @(negedge clk_i);
    end
  endtask

  task automatic test_invalid_and_clamp;
    logic [4:0] bad;
    for (int i = 1; i <= 2; i++) begin
      bad = 5'(i);
      present(16'hFFFF, bad);
      for (int c = 0; c < 3; c++) begin
        tests_run++;
        if (ser_data_val_o !== 1'b0 || busy_o !== 1'b0 || ser_data_o !== 1'b0) begin
          tests_failed++;
          $display("FAIL invalid mod%0d c%0d: data=%b val=%b busy=%b expected 0 0 0",
                   i, c, ser_data_o, ser_data_val_o, busy_o);
        end
        @(negedge clk_i);
      end
    end
    present(16'h1234, 5'd20);
    for (int k = 0; k < 16; k++) begin
      tests_run++;
      if (ser_data_val_o !== 1'b1 || busy_o !== 1'b1 || ser_data_o !== exp_bit(16'h1234, 16, k)) begin
        tests_failed++;
        $display("FAIL clamp bit%0d: data=%b val=%b busy=%b expected data=%b val=1 busy=1",
                 k, ser_data_o, ser_data_val_o, busy_o, exp_bit(16'h1234, 16, k));
      end
      @(negedge clk_i);
    end
    tests_run++;
    if (ser_data_val_o !== 1'b0 || busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL clamp_end: val=%b busy=%b expected 0 0", ser_data_val_o, busy_o);
    end
  endtask

  task automatic test_busy_ignore;
    present(16'hFFFF, 5'd0);
    for (int k = 0; k < 16; k++) begin
      tests_run++;
      if (ser_data_val_o !== 1'b1 || busy_o !== 1'b1 || ser_data_o !== 1'b1) begin
        tests_failed++;
        $display("FAIL busy_ignore bit%0d: data=%b val=%b busy=%b expected 1 1 1",
                 k, ser_data_o, ser_data_val_o, busy_o);
      end
      if (k == 3) begin
        data_i     = 16'h0000;
        data_mod_i = 5'd0;
        data_val_i = 1'b1;
      end else begin
        data_val_i = 1'b0;
      end
      @(negedge clk_i);
    end
    for (int c = 0; c < 4; c++) begin
      tests_run++;
      if (ser_data_o !== 1'b0 || ser_data_val_o !== 1'b0 || busy_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL busy_ignore_end c%0d: data=%b val=%b busy=%b expected 0 0 0",
                 c, ser_data_o, ser_data_val_o, busy_o);
      end
      @(negedge clk_i);
    end
  endtask

  task automatic test_mid_reset;
    present(16'hA5C3, 5'd0);
    for (int k = 0; k < 4; k++) @(negedge clk_i);
    tests_run++;
    if (ser_data_val_o !== 1'b1 || ser_data_o !== exp_bit(16'hA5C3, 16, 4)) begin
      tests_failed++;
      $display("FAIL mid_reset bit4: data=%b val=%b expected data=%b val=1",
               ser_data_o, ser_data_val_o, exp_bit(16'hA5C3, 16, 4));
    end
    srst_i = 1'b1;
    @(negedge clk_i);
    srst_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tests_run++;
      if (ser_data_o !== 1'b0 || ser_data_val_o !== 1'b0 || busy_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL mid_reset_after c%0d: data=%b val=%b busy=%b expected 0 0 0",
                 c, ser_data_o, ser_data_val_o, busy_o);
      end
      @(negedge clk_i);
    end
    present(16'h8000, 5'd3);
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (ser_data_val_o !== 1'b1 || busy_o !== 1'b1 || ser_data_o !== exp_bit(16'h8000, 3, k)) begin
        tests_failed++;
        $display("FAIL post_reset bit%0d: data=%b val=%b busy=%b expected data=%b val=1 busy=1",
                 k, ser_data_o, ser_data_val_o, busy_o, exp_bit(16'h8000, 3, k));
      end
      @(negedge clk_i);
    end
    tests_run++;
    if (ser_data_val_o !== 1'b0 || busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset_end: val=%b busy=%b expected 0 0", ser_data_val_o, busy_o);
    end
  endtask

  task automatic test_back_to_back;
    present(16'h9000, 5'd4);
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (ser_data_val_o !== 1'b1 || ser_data_o !== exp_bit(16'h9000, 4, k)) begin
        tests_failed++;
        $display("FAIL b2b_first bit%0d: data=%b val=%b expected data=%b val=1",
                 k, ser_data_o, ser_data_val_o, exp_bit(16'h9000, 4, k));
      end
      if (k < 3) @(negedge clk_i);
    end
    // Next negedge is the single idle cycle; present the second word there.
    @(negedge clk_i);
    tests_run++;
    if (busy_o !== 1'b0 || ser_data_val_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_gap: val=%b busy=%b expected 0 0", ser_data_val_o, busy_o);
    end
    data_i     = 16'hC000;
    data_mod_i = 5'd3;
    data_val_i = 1'b1;
    @(negedge clk_i);
    data_val_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (ser_data_val_o !== 1'b1 || busy_o !== 1'b1 || ser_data_o !== exp_bit(16'hC000, 3, k)) begin
        tests_failed++;
        $display("FAIL b2b_second bit%0d: data=%b val=%b busy=%b expected data=%b val=1 busy=1",
                 k, ser_data_o, ser_data_val_o, busy_o, exp_bit(16'hC000, 3, k));
      end
      @(negedge clk_i);
    end
    tests_run++;
    if (ser_data_val_o !== 1'b0 || busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_end: val=%b busy=%b expected 0 0", ser_data_val_o, busy_o);
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_partial_word();
    test_invalid_and_clamp();
    test_busy_ignore();
    test_mid_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/serializer.md
Name: serializer

Overview:
- Parallel-to-serial converter: accepts a DATA_W-bit word plus a bit count, then shifts out the selected most-significant bits one per clock, MSB first.
- Sits between a word-oriented producer and a single-bit serial link.
- busy_o provides back-pressure; the producer must not present a word while busy_o is high.

Parameters:
- DATA_W, 16, input word width; must be a power of two and >= 4.
- MOD_W, $clog2(DATA_W)+1 (5), width of data_mod_i.

Ports:
- clk_i  in  1  single clock; all logic on its rising edge.
- srst_i  in  1  synchronous reset, active-high.
- data_i  in  DATA_W  parallel word to serialize.
- data_mod_i  in  MOD_W  number of bits to send, counted from data_i[DATA_W-1] downward; 0 means all DATA_W bits.
- data_val_i  in  1  data_i/data_mod_i valid this cycle.
- ser_data_o  out  1  serial data bit.
- ser_data_val_o  out  1  ser_data_o valid this cycle.
- busy_o  out  1  a transfer is in progress; new input is ignored.

Behaviour:
- Reset: srst_i=1 at an edge clears ser_data_o=0, ser_data_val_o=0, busy_o=0 and the internal shift register/counter. Reset has priority over everything, including mid-transfer; the current word is abandoned with no further output.
- States: IDLE, SHIFT.
- Effective length N:
  - data_mod_i==0 gives N=DATA_W.
  - data_mod_i in 3..DATA_W gives N=data_mod_i.
  - data_mod_i>DATA_W is clamped to N=DATA_W.
  - data_mod_i 1 or 2 is invalid; the word is dropped and the block stays IDLE with no outputs.
- Acceptance: in IDLE, data_val_i=1 with valid N latches data_i and N at that edge and moves to SHIFT.
- data_val_i while in SHIFT is ignored; the latched word is unaffected.
- Latency: the first bit appears in the cycle directly after the accepting edge.
  - Cycle k (k=0..N-1) after acceptance drives ser_data_o=word[DATA_W-1-k], ser_data_val_o=1, busy_o=1.
- Completion: after bit N-1 the block returns to IDLE.
  - The next cycle has ser_data_val_o=0 and busy_o=0.
  - A new word may be accepted on the edge ending that idle cycle.
- busy_o and ser_data_val_o are asserted for exactly N consecutive cycles per accepted word.
- When ser_data_val_o=0, ser_data_o is driven 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro SERIALIZER_LSB_FIRST_EN.
- Defined: the same N bits (data_i[DATA_W-1 : DATA_W-N]) are sent in reverse order, starting with data_i[DATA_W-N] and ending with data_i[DATA_W-1]. Timing, busy_o and length rules are unchanged.
- Undefined (default): MSB-first order as above.

Decomposition:
- Package serializer_pkg holds the DATA_W/MOD_W defaults, the state enum (IDLE, SHIFT), and a constant for the minimum valid mod (3).
- No sub-module is needed; one shift register, one down-counter and a 2-state FSM in a single module.

Test Plan:
- Reset: hold srst_i 2 cycles -> ser_data_o=0, ser_data_val_o=0, busy_o=0 throughout and after.
- Full word: data_i=16'hA5C3, mod=0, one-cycle data_val_i.
  - Next 16 cycles ser_data_o=1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1 with ser_data_val_o=busy_o=1.
  - Then both drop to 0.
- Partial word: data_i=16'hF000, mod=5 -> exactly 5 valid cycles with bits 1,1,1,1,0; busy_o high exactly 5 cycles.
- Invalid mod: mod=1, then mod=2 with data_val_i -> no ser_data_val_o, busy_o stays 0. Clamp check: mod=20 -> 16 bits sent.
- Busy ignore: during a 16-bit transfer of 16'hFFFF, pulse data_val_i with 16'h0000/mod=0 -> all 16 output bits remain 1; no second transfer follows.
- Mid-transfer reset: assert srst_i at bit 4 of a 16-bit word -> outputs 0 on the next cycle. A following word (16'h8000, mod=3) -> bits 1,0,0.
